// File: rtl/enc_pkg.sv
// Shared types and constants for the LEGv8 instruction encoder: format enum,
// opcode fields and the legal immediate range of each instruction class.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_LDUR  = 3'd0,
    FMT_STUR  = 3'd1,
    FMT_CBZ   = 3'd2,
    FMT_BCOND = 3'd3,
    FMT_ADDI  = 3'd4,
    FMT_SUBI  = 3'd5
  } fmt_t;

  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [9:0]  OP_ADDI  = 10'h244;
  localparam logic [9:0]  OP_SUBI  = 10'h344;

  localparam logic signed [63:0] D_MIN  = -64'sd256;
  localparam logic signed [63:0] D_MAX  = 64'sd255;
  localparam logic signed [63:0] CB_MIN = -64'sd262144;
  localparam logic signed [63:0] CB_MAX = 64'sd262143;
  localparam logic [63:0]        I_MAX  = 64'd4095;

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: instruction fields -> 32-bit LEGv8 word plus a bad flag.
// Range violations only raise bad when ENC_RANGE_CHECK_EN is defined.
module imm_field_pack
  import enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [63:0] imm,
  output logic [31:0] inst,
  output logic        bad
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic d_out, cb_out, i_out;

  always_comb begin
    d_out  = ($signed(imm) < D_MIN)  || ($signed(imm) > D_MAX);
    cb_out = ($signed(imm) < CB_MIN) || ($signed(imm) > CB_MAX);
    // ADDI/SUBI immediates are unsigned, so negative values land far above I_MAX
    i_out  = imm > I_MAX;
  end

  always_comb begin
    inst = '0;
    bad  = 1'b0;
    case (fmt)
      FMT_LDUR: begin
        inst = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
        bad  = RANGE_CHECK & d_out;
      end
      FMT_STUR: begin
        inst = {OP_STUR, imm[8:0], 2'b00, rn, rd};
        bad  = RANGE_CHECK & d_out;
      end
      FMT_CBZ: begin
        inst = {OP_CBZ, imm[18:0], rd};
        bad  = RANGE_CHECK & cb_out;
      end
      FMT_BCOND: begin
        inst = {OP_BCOND, imm[18:0], rd};
        bad  = RANGE_CHECK & cb_out;
      end
      FMT_ADDI: begin
        inst = {OP_ADDI, imm[11:0], rn, rd};
        bad  = RANGE_CHECK & i_out;
      end
      FMT_SUBI: begin
        inst = {OP_SUBI, imm[11:0], rn, rd};
        bad  = RANGE_CHECK & i_out;
      end
      default: begin
        inst = '0;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder: one-stage registered pipeline emitting packed words
// with an imem word address. Optional range checking via ENC_RANGE_CHECK_EN.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  // Handshake: a beat moves on a side when valid & ready are both high at posedge;
  // valid never waits on ready, and a stalled output word holds all its fields.
  logic        accept, xfer;
  logic [31:0] pack_inst;
  logic        pack_bad;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  imm_field_pack u_pack (
    .fmt  (in_fmt),
    .rd   (in_rd),
    .rn   (in_rn),
    .imm  (in_imm),
    .inst (pack_inst),
    .bad  (pack_bad)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= pack_inst;
      out_err   <= pack_bad;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // out_addr is the address of the word on the output; it advances past each
  // transferred word so a same-cycle refill lands on the next address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_addr <= '0;
    end else if (clr) begin
      out_addr <= '0;
    end else if (xfer) begin
      out_addr <= out_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (xfer && out_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus random traffic,
// scored against a field-arithmetic reference model through an expected queue.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset, clr, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rn;
  logic [63:0] in_imm;
  logic [31:0] out_inst;
  logic [7:0]  out_addr, err_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];  // {err, inst}
  logic [7:0]  m_addr = 8'd0;
  int          m_errcnt = 0;

  inst_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rn(in_rn), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32:0] model(input logic [2:0] f, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [63:0] imm);
    longint          s;
    longint unsigned u, w, r_d, r_n;
    bit              bad;
    s = longint'(imm);
    u = imm;
    r_d = 64'(rd);
    r_n = 64'(rn);
    w = 0;
    bad = 0;
    case (f)
      3'd0, 3'd1: begin
        w = ((f == 3'd0) ? 64'h7C2 : 64'h7C0) * 64'd2097152 + (u % 512) * 4096 + r_n * 32 + r_d;
        bad = (s < -256) || (s > 255);
      end
      3'd2, 3'd3: begin
        w = ((f == 3'd2) ? 64'hB4 : 64'h54) * 64'd16777216 + (u % 524288) * 32 + r_d;
        bad = (s < -262144) || (s > 262143);
      end
      3'd4, 3'd5: begin
        w = ((f == 3'd4) ? 64'h244 : 64'h344) * 64'd4194304 + (u % 4096) * 1024 + r_n * 32 + r_d;
        bad = u > 4095;
      end
      default: return {1'b1, 32'h0};
    endcase
`ifdef ENC_RANGE_CHECK_EN
    return {bad, w[31:0]};
`else
    return {1'b0, w[31:0]};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at posedge+1, score the accept at negedge, return at next posedge+1.
  task automatic step(input logic v, input logic r, input logic [2:0] f, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [63:0] imm, input logic c);
    in_valid = v; out_ready = r; clr = c;
    in_fmt = f; in_rd = rd; in_rn = rn; in_imm = imm;
    @(negedge clk);
    if (v && in_ready) exp_q.push_back(model(f, rd, rn, imm));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, r, 3'd0, 5'd0, 5'd0, 64'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(1'b1);
  endtask

  function automatic logic [63:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 600)) - 64'd300;
      2: return ($urandom_range(0, 1) != 0) ? 64'd262140 + 64'($urandom_range(0, 7))
                                            : 64'd0 - 64'd262140 - 64'($urandom_range(0, 7));
      default: return 64'd4090 + 64'($urandom_range(0, 10));
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      m_addr = 8'd0;
      m_errcnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_inst);
        end else begin
          e = exp_q.pop_front();
          chk("out_inst", 64'(out_inst), 64'(e[31:0]));
          chk("out_err", 64'(out_err), 64'(e[32]));
          chk("out_addr", 64'(out_addr), 64'(m_addr));
          chk("err_cnt", 64'(err_cnt), 64'(m_errcnt));
          if (e[32] && m_errcnt < 255) m_errcnt++;
        end
        m_addr = clr ? 8'd0 : m_addr + 8'd1;
      end else if (clr) begin
        m_addr = 8'd0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held_inst;
    logic [7:0]  held_addr;
    logic [32:0] e;

    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_rd = '0; in_rn = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b1;
    idle(1'b1);

    // LDUR example, then ADDI/CBZ back to back
    step(1'b1, 1'b1, 3'd0, 5'd1, 5'd2, 64'd8, 1'b0);
    chk("ldur_valid", 64'(out_valid), 64'd1);
    chk("ldur_inst", 64'(out_inst), 64'hF8408041);
    chk("ldur_addr", 64'(out_addr), 64'd0);
    drain();
    step(1'b1, 1'b1, 3'd4, 5'd3, 5'd4, 64'd4095, 1'b0);
    chk("addi_inst", 64'(out_inst), 64'h913FFC83);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 1'b1, 3'd2, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("cbz_inst", 64'(out_inst), 64'hB4FFFFE5);
    chk("cbz_addr", 64'(out_addr), 64'd2);
    drain();

    // stall: word pending with out_ready low for 3 cycles
    step(1'b1, 1'b0, 3'd1, 5'd7, 5'd9, 64'd17, 1'b0);
    held_inst = out_inst;
    held_addr = out_addr;
    e = model(3'd1, 5'd7, 5'd9, 64'd17);
    chk("stall_first_inst", 64'(held_inst), 64'(e[31:0]));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'd5, 5'd2, 5'd6, 64'd100, 1'b0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_inst", 64'(out_inst), 64'(held_inst));
      chk("stall_addr", 64'(out_addr), 64'(held_addr));
    end
    chk("stall_queue_len", 64'(exp_q.size()), 64'd1);
    step(1'b1, 1'b1, 3'd5, 5'd2, 5'd6, 64'd100, 1'b0);
    chk("release_queue_len", 64'(exp_q.size()), 64'd1);
    drain();

    // range boundary and unknown fmt
    step(1'b1, 1'b1, 3'd0, 5'd1, 5'd1, 64'd256, 1'b0);
`ifdef ENC_RANGE_CHECK_EN
    chk("ldur256_err", 64'(out_err), 64'd1);
`else
    chk("ldur256_err", 64'(out_err), 64'd0);
`endif
    step(1'b1, 1'b1, 3'd7, 5'd3, 5'd3, 64'd5, 1'b0);
    chk("fmt7_inst", 64'(out_inst), 64'd0);
    chk("fmt7_err", 64'(out_err), 64'd1);
    drain();

    // clr in the transfer cycle of the word at address 5
    step(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 64'd0, 1'b1);
    chk("clr_idle_addr", 64'(out_addr), 64'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 3'(i % 6), 5'(i), 5'(i + 1), 64'(i * 3), i == 6);
    end
    chk("clr_next_addr", 64'(out_addr), 64'd0);
    drain();

    // wrap: 257 flagged words also drive err_cnt into saturation
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 3'd7, 5'(i), 5'(i), 64'(i), 1'b0);
    drain();
    chk("err_cnt_sat", 64'(err_cnt), 64'hFF);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           5'($urandom), 5'($urandom), rand_imm(), $urandom_range(0, 31) == 0);
    end
    drain();

    // reset while a word is stalled
    step(1'b1, 1'b0, 3'd7, 5'd1, 5'd1, 64'd0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_addr", 64'(out_addr), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    idle(1'b1);
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
